grid_row_mem: RTL and testbench

Parametrised row-organised grid memory for the Tetris playfield: one word per row, one bit per column. It provides a read/write port for the piece/lock logic and a read-only port for the display scanner. Both ports use write-first bypass. A built-in sequential engine performs line clears by shifting all rows above a given row down by one, and can also wipe the whole grid. It sits between the game controller (port A, clear/wipe commands) and the VGA row renderer (port B).

---
 rtl/grid_row_mem.sv | 153 +++++++++++++++
 tb/tb_grid_row_mem.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/grid_row_mem.sv
// Row-organised Tetris playfield memory: one word per row, one bit per column.
// Port A read/write, port B read-only, plus a line-clear / wipe engine.
module grid_row_mem #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  clr_req,
  input  logic [ADDR_WIDTH-1:0] clr_row,
  input  logic                  wipe_req,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  full_a,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_WIPE  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(DEPTH - 1);

  // Contents come up as an empty playfield; reset deliberately leaves them alone.
  logic [DATA_WIDTH-1:0] ram [DEPTH] = '{default: '0};

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] ptr_m1;

  logic                  a_ok;
  logic                  b_ok;
  logic                  clr_ok;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  assign a_ok   = {1'b0, addr_a}  < DEPTH_W;
  assign b_ok   = {1'b0, addr_b}  < DEPTH_W;
  assign clr_ok = {1'b0, clr_row} < DEPTH_W;
  assign ptr_m1 = ptr - 1'b1;

  // Port A and the engine never write in the same cycle, so one write port suffices.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ptr;
    wr_data = '0;
    case (state)
      ST_IDLE: begin
        if (we_a && a_ok) begin
          wr_en   = 1'b1;
          wr_addr = addr_a;
          wr_data = data_a;
        end
      end
      ST_SHIFT: begin
        wr_en = 1'b1;
        if (ptr != '0) begin
          wr_data = ram[ptr_m1];
        end
      end
      ST_WIPE: begin
        wr_en = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Write-first: a write to the row being read this cycle is forwarded.
  always_comb begin
    rd_a = '0;
    if (a_ok) begin
      rd_a = ram[addr_a];
    end
    if (wr_en && (wr_addr == addr_a)) begin
      rd_a = wr_data;
    end
  end

  always_comb begin
    rd_b = '0;
    if (b_ok) begin
      rd_b = ram[addr_b];
    end
    if (wr_en && (wr_addr == addr_b)) begin
      rd_b = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a    <= '0;
      q_b    <= '0;
      full_a <= 1'b0;
    end else begin
      q_a    <= rd_a;
      q_b    <= rd_b;
      full_a <= &rd_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wipe_req) begin
            state <= ST_WIPE;
            ptr   <= LAST_ROW;
          end else if (clr_req && clr_ok) begin
            state <= ST_SHIFT;
            ptr   <= clr_row;
          end
        end
        ST_SHIFT, ST_WIPE: begin
          if (ptr == '0) begin
            state <= ST_DONE;
          end else begin
            ptr <= ptr_m1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_grid_row_mem.sv
// Directed bench for grid_row_mem: bypass reads, line clears, wipe,
// out-of-range handling and reset during a clear.
module tb_grid_row_mem;

  logic       clk;
  logic       rst_n;
  logic [9:0] data_a;
  logic [4:0] addr_a;
  logic       we_a;
  logic [4:0] addr_b;
  logic       clr_req;
  logic [4:0] clr_row;
  logic       wipe_req;
  logic [9:0] q_a;
  logic [9:0] q_b;
  logic       full_a;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  grid_row_mem #(
    .DATA_WIDTH (10),
    .ADDR_WIDTH (5),
    .DEPTH      (20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_a   (data_a),
    .addr_a   (addr_a),
    .we_a     (we_a),
    .addr_b   (addr_b),
    .clr_req  (clr_req),
    .clr_row  (clr_row),
    .wipe_req (wipe_req),
    .q_a      (q_a),
    .q_b      (q_b),
    .full_a   (full_a),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int row, input logic [9:0] val);
    addr_a = 5'(row);
    data_a = val;
    we_a   = 1'b1;
    tick();
    we_a   = 1'b0;
  endtask

  task automatic read_row(input int row, output logic [9:0] va, output logic [9:0] vb);
    addr_a = 5'(row);
    addr_b = 5'(row);
    tick();
    va = q_a;
    vb = q_b;
  endtask

  // Counts busy cycles and done pulses; optionally hammers port A meanwhile.
  task automatic run_engine(input logic poke, output int cycles, output int dones);
    cycles = 0;
    dones  = 0;
    while (busy && cycles < 100) begin
      cycles++;
      if (done) dones++;
      if (poke) begin
        we_a   = 1'b1;
        addr_a = 5'(cycles % 20);
        data_a = 10'h3FF;
      end
      tick();
    end
    we_a = 1'b0;
  endtask

  initial begin
    logic [9:0] va, vb;
    int cyc, dn;

    rst_n = 1'b1; data_a = '0; addr_a = '0; we_a = 1'b0; addr_b = '0;
    clr_req = 1'b0; clr_row = '0; wipe_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_q_a", 32'(q_a), 0);
    check("rst_q_b", 32'(q_b), 0);
    check("rst_full", 32'(full_a), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Write-first bypass on both ports
    addr_b = 5'd5;
    write_row(5, 10'h3FF);
    check("byp_q_a", 32'(q_a), 32'h3FF);
    check("byp_q_b", 32'(q_b), 32'h3FF);
    check("byp_full", 32'(full_a), 1);
    read_row(0, va, vb);
    check("full_drop", 32'(full_a), 0);
    read_row(5, va, vb);
    check("rb5_a", 32'(va), 32'h3FF);
    check("rb5_full", 32'(full_a), 1);

    // Clear of the bottom row with rows holding their index
    for (int k = 0; k < 20; k++) write_row(k, 10'(k));
    clr_row = 5'd19;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    run_engine(1'b0, cyc, dn);
    check("clr19_busy_cycles", 32'(cyc), 21);
    check("clr19_done_pulses", 32'(dn), 1);
    for (int k = 0; k < 20; k++) begin
      read_row(k, va, vb);
      check($sformatf("clr19_a_row%0d", k), 32'(va), (k == 0) ? 0 : 32'(k - 1));
      check($sformatf("clr19_b_row%0d", k), 32'(vb), (k == 0) ? 0 : 32'(k - 1));
    end

    // Clear of the top row only touches row 0
    write_row(0, 10'h155);
    clr_row = 5'd0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    run_engine(1'b0, cyc, dn);
    check("clr0_busy_cycles", 32'(cyc), 2);
    check("clr0_done_pulses", 32'(dn), 1);
    for (int k = 0; k < 20; k++) begin
      read_row(k, va, vb);
      check($sformatf("clr0_row%0d", k), 32'(va), (k == 0) ? 0 : 32'(k - 1));
    end

    // Out-of-range clear request and write
    clr_row = 5'd25;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("oor_clr_busy", 32'(busy), 0);
    check("oor_clr_done", 32'(done), 0);
    tick();
    check("oor_clr_busy2", 32'(busy), 0);
    read_row(19, va, vb);
    check("oor_clr_row19", 32'(va), 18);
    read_row(7, va, vb);
    check("oor_clr_row7", 32'(vb), 6);
    addr_b = 5'd25;
    write_row(25, 10'h3FF);
    check("oor_wr_q_a", 32'(q_a), 0);
    check("oor_wr_q_b", 32'(q_b), 0);
    check("oor_wr_full", 32'(full_a), 0);
    read_row(25, va, vb);
    check("oor_rd_a", 32'(va), 0);
    check("oor_rd_b", 32'(vb), 0);

    // Wipe beats a simultaneous clear; port A writes ignored while busy
    wipe_req = 1'b1;
    clr_req  = 1'b1;
    clr_row  = 5'd3;
    tick();
    wipe_req = 1'b0;
    clr_req  = 1'b0;
    run_engine(1'b1, cyc, dn);
    check("wipe_busy_cycles", 32'(cyc), 21);
    check("wipe_done_pulses", 32'(dn), 1);
    check("wipe_done_low", 32'(done), 0);
    for (int k = 0; k < 20; k++) begin
      read_row(k, va, vb);
      check($sformatf("wipe_row%0d", k), 32'(va | vb), 0);
    end

    // Reset after three shift writes of a clear at row 10
    for (int k = 0; k < 20; k++) write_row(k, 10'h100 + 10'(k));
    addr_a  = 5'd15;
    addr_b  = 5'd2;
    clr_row = 5'd10;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("mid_busy", 32'(busy), 1);
    tick();
    tick();
    tick();
    check("mid_q_a_pre", 32'(q_a), 32'h10F);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_q_a", 32'(q_a), 0);
    check("mid_rst_q_b", 32'(q_b), 0);
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      if (done) cyc++;
      tick();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) cyc++;
      tick();
    end
    check("mid_no_done", 32'(cyc), 0);
    for (int k = 0; k < 20; k++) begin
      read_row(k, va, vb);
      check($sformatf("mid_row%0d", k), 32'(va),
            (k >= 8 && k <= 10) ? 32'(10'h100 + 10'(k - 1)) : 32'(10'h100 + 10'(k)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
